// File: rtl/e_door_ctrl_pkg.sv
// Purpose: shared elevator door types and feedback patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by the door controller, the door animation block and the car controller.
package e_door_ctrl_pkg;

  // Door sequencer states.
  typedef enum logic [1:0] {
    CLOSED     = 2'd0,
    OPENING    = 2'd1,
    OPEN_DWELL = 2'd2,
    CLOSING    = 2'd3
  } door_state_t;

  // Animation bar end points; every other bar value means "moving".
  localparam logic [3:0] DOOR_OPEN_PAT   = 4'b0000;
  localparam logic [3:0] DOOR_CLOSED_PAT = 4'b1111;

endpackage

// File: rtl/e_dwell_timer.sv
// Purpose: open-door dwell counter: load DWELL, count down, flag the last cycle.
// Latency: load/decrement take effect on the next clk edge; expire is combinational from the count.
// Backpressure: none; load has priority over dec, and the count never drops below 1 once loaded.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset (count cleared to 0)
//   load        - reload the count with DWELL
//   dec         - decrement by one (held at 1, never wraps)
//   expire      - count == 1, i.e. this is the last dwell cycle
module e_dwell_timer #(
  parameter int CNT_W = 8,
  parameter int DWELL = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam logic [CNT_W-1:0] DWELL_V = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DWELL_V;
    end else if (dec && (cnt > ONE)) begin
      cnt <= cnt - ONE;
    end
  end

  assign expire = (cnt == ONE);

endmodule

// File: rtl/e_door_ctrl.sv
// Purpose: door command sequencer driving the one-hot dO/dC commands into the door animation.
// Latency: outputs are registers loaded with the decode of the next state, 1 cycle after the triggering input.
// Backpressure: none; a stuck feedback bar simply holds OPENING/CLOSING, with no timeout here.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset (forces CLOSING)
//   arrive                - 1-cycle pulse, car stopped at a served floor (ignored unless CLOSED)
//   open_btn, close_btn   - door open / close requests (levels)
//   obstruct              - door-edge obstruction sensor (level)
//   door[3:0]             - animation feedback bar, 0000 = open, 1111 = closed
//   dO, dC                - open / close step commands, never high together
//   door_busy             - door not in CLOSED, car motion inhibited
//   door_closed           - CLOSED with the bar reading fully closed
module e_door_ctrl
  import e_door_ctrl_pkg::*;
#(
  parameter int DWELL = 8,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrive,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic [3:0] door,
  output logic       dO,
  output logic       dC,
  output logic       door_busy,
  output logic       door_closed
);

  door_state_t state;
  door_state_t state_nxt;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_expire;

  logic at_open;
  logic at_closed;
  logic reopen;

  assign at_open   = (door == DOOR_OPEN_PAT);
  assign at_closed = (door == DOOR_CLOSED_PAT);
  assign reopen    = obstruct | open_btn;

  e_dwell_timer #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .expire (tmr_expire)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    unique case (state)
      CLOSED: begin
        // obstruct alone must not open a closed door
        if (arrive || open_btn) begin
          state_nxt = OPENING;
        end
      end
      OPENING: begin
        // an open in progress cannot be cancelled; only the end point matters
        if (at_open) begin
          state_nxt = OPEN_DWELL;
          tmr_load  = 1'b1;
        end
      end
      OPEN_DWELL: begin
        // obstruct and open_btn both restart the dwell and beat close_btn
        if (reopen) begin
          tmr_load = 1'b1;
        end else if (close_btn || tmr_expire) begin
          state_nxt = CLOSING;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CLOSING: begin
        // re-open beats reaching the closed end point in the same cycle
        if (reopen) begin
          state_nxt = OPENING;
        end else if (at_closed) begin
          state_nxt = CLOSED;
        end
      end
      default: begin
        state_nxt = CLOSING;
      end
    endcase
  end

  // Outputs are a registered decode of state_nxt, so they change on the same
  // edge as the state; dO and dC come from distinct states and cannot overlap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLOSING;
      dO          <= 1'b0;
      dC          <= 1'b0;
      door_busy   <= 1'b1;
      door_closed <= 1'b0;
    end else begin
      state       <= state_nxt;
      dO          <= (state_nxt == OPENING);
      dC          <= (state_nxt == CLOSING);
      door_busy   <= (state_nxt != CLOSED);
      door_closed <= (state_nxt == CLOSED) && at_closed;
    end
  end

endmodule

// File: tb/tb_e_door_ctrl.sv
// Purpose: self-checking bench for e_door_ctrl with a door animation model and a reference model.
// Latency: samples outputs on the falling edge, one rising edge after inputs are driven.
// Backpressure: n/a.
module tb_e_door_ctrl;

  localparam int DWELL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arrive = 1'b0;
  logic       open_btn = 1'b0;
  logic       close_btn = 1'b0;
  logic       obstruct = 1'b0;
  logic [3:0] door;
  logic       dO, dC, door_busy, door_closed;

  // door source: either the animation model or a forced value from the table
  logic       anim_en = 1'b0;
  logic       anim_init = 1'b0;
  logic [3:0] anim_door = 4'b0000;
  logic [3:0] forced_door = 4'b0000;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign door = anim_en ? anim_door : forced_door;

  // Animation: bar is MSB-justified; closing grows it, opening shrinks it, one step per cycle.
  always @(posedge clk) begin
    if (anim_init) anim_door <= 4'b0000;
    else if (dO && !dC) anim_door <= {anim_door[2:0], 1'b0};
    else if (dC && !dO) anim_door <= {1'b1, anim_door[3:1]};
  end

  e_door_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arrive      (arrive),
    .open_btn    (open_btn),
    .close_btn   (close_btn),
    .obstruct    (obstruct),
    .door        (door),
    .dO          (dO),
    .dC          (dC),
    .door_busy   (door_busy),
    .door_closed (door_closed)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("excl_dO_dC", {3'b000, dO & dC}, 4'b0000);
  endtask

  task automatic wait_dO_low(input string name);
    int g = 0;
    while (dO && g < 50) begin tick(); g++; end
    check({name, "_open_timeout"}, {3'b000, g >= 50}, 4'b0000);
  endtask

  task automatic wait_closed(input string name);
    int g = 0;
    while (!door_closed && g < 50) begin tick(); g++; end
    check({name, "_close_timeout"}, {3'b000, g >= 50}, 4'b0000);
    check({name, "_closed_bar"}, door, 4'b1111);
  endtask

  task automatic wait_door(input string name, input logic [3:0] pat);
    int g = 0;
    while (door != pat && g < 50) begin tick(); g++; end
    check({name, "_bar_timeout"}, {3'b000, g >= 50}, 4'b0000);
  endtask

  // counts idle dwell cycles (dO=dC=0) until dC rises
  task automatic count_to_dC(input string name);
    int n = 0;
    while (!dC && n < 100) begin
      if (dO) n = 100;
      else begin n++; tick(); end
    end
    check({name, "_dwell_len"}, 4'(n), 4'(DWELL));
  endtask

  task automatic pulse_arrive();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    check("arrive_dO_next", {3'b000, dO}, 4'b0001);
  endtask

  // Reference model: door phase plus dwell cycles remaining.
  localparam int P_SHUT = 0, P_OPENING = 1, P_HELD = 2, P_CLOSING = 3;
  int m_phase = P_CLOSING;
  int m_left = 0;
  logic [3:0] m_exp;  // {dO, dC, busy, closed}

  task automatic model_step(input logic r, input logic a, input logic ob, input logic cb,
                            input logic obs, input logic [3:0] d);
    if (!r) begin
      m_phase = P_CLOSING;
      m_left  = 0;
      m_exp   = 4'b0010;
    end else begin
      if (m_phase == P_SHUT) begin
        if (a || ob) m_phase = P_OPENING;
      end else if (m_phase == P_OPENING) begin
        if (d == 4'b0000) begin m_phase = P_HELD; m_left = DWELL; end
      end else if (m_phase == P_HELD) begin
        if (obs || ob) m_left = DWELL;
        else if (cb || m_left == 1) m_phase = P_CLOSING;
        else m_left = m_left - 1;
      end else begin
        if (obs || ob) m_phase = P_OPENING;
        else if (d == 4'b1111) m_phase = P_SHUT;
      end
      m_exp = {m_phase == P_OPENING, m_phase == P_CLOSING, m_phase != P_SHUT,
               (m_phase == P_SHUT) && (d == 4'b1111)};
    end
  endtask

  typedef struct packed {
    logic [4:0] in;   // {rst_n, arrive, open_btn, close_btn, obstruct}
    logic [3:0] door;
    logic [3:0] exp;  // {dO, dC, door_busy, door_closed}
  } vec_t;

  vec_t vecs[22];

  initial begin
    vecs[0]  = {5'b0_0000, 4'b0000, 4'b0010};  // in reset
    vecs[1]  = {5'b1_0000, 4'b0000, 4'b0110};  // released: closes
    vecs[2]  = {5'b1_0000, 4'b1000, 4'b0110};
    vecs[3]  = {5'b1_0000, 4'b1111, 4'b0001};  // reached closed
    vecs[4]  = {5'b1_0001, 4'b1111, 4'b0001};  // obstruct alone stays closed
    vecs[5]  = {5'b1_1000, 4'b1111, 4'b1010};  // arrive opens
    vecs[6]  = {5'b1_1010, 4'b1111, 4'b1010};  // inputs ignored while opening
    vecs[7]  = {5'b1_0000, 4'b0110, 4'b1010};  // odd bar = moving
    vecs[8]  = {5'b1_0000, 4'b0000, 4'b0010};  // open, dwell
    vecs[9]  = {5'b1_0000, 4'b0000, 4'b0010};
    vecs[10] = {5'b1_0110, 4'b0000, 4'b0010};  // open+close: open wins
    vecs[11] = {5'b1_0010, 4'b0000, 4'b0110};  // close_btn closes now
    vecs[12] = {5'b1_0100, 4'b1100, 4'b1010};  // open_btn re-opens
    vecs[13] = {5'b1_0000, 4'b1000, 4'b1010};
    vecs[14] = {5'b1_0000, 4'b0000, 4'b0010};
    vecs[15] = {5'b1_0010, 4'b0000, 4'b0110};
    vecs[16] = {5'b1_0001, 4'b1111, 4'b1010};  // re-open beats closed end point
    vecs[17] = {5'b1_0000, 4'b1111, 4'b1010};  // waits for 0000
    vecs[18] = {5'b0_0000, 4'b1000, 4'b0010};  // reset mid-open
    vecs[19] = {5'b1_0000, 4'b1000, 4'b0110};
    vecs[20] = {5'b1_0000, 4'b1111, 4'b0001};
    vecs[21] = {5'b1_0100, 4'b1111, 4'b1010};  // open_btn opens

    // ---- table-driven vectors with forced feedback ----
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      {rst_n, arrive, open_btn, close_btn, obstruct} = vecs[i].in;
      forced_door = vecs[i].door;
      tick();
      check($sformatf("vec%0d", i), {dO, dC, door_busy, door_closed}, vecs[i].exp);
    end
    {rst_n, arrive, open_btn, close_btn, obstruct} = 5'b0_0000;

    // ---- power-up: animation starts open ----
    anim_en = 1'b1;
    anim_init = 1'b1;
    tick();
    tick();
    check("reset_outputs", {dO, dC, door_busy, door_closed}, 4'b0010);
    anim_init = 1'b0;
    rst_n = 1'b1;
    tick();
    check("pwrup_dC_first", {3'b000, dC}, 4'b0001);
    begin
      int steps = 0;
      int g = 0;
      while (!door_closed && g < 30) begin
        if (dC && door != 4'b1111) steps++;
        tick();
        g++;
      end
      check("pwrup_close_steps", 4'(steps), 4'd4);
    end
    check("pwrup_idle", {dO, dC, door_busy, door_closed}, 4'b0001);

    // ---- full arrive cycle ----
    pulse_arrive();
    wait_dO_low("cycle");
    count_to_dC("cycle");
    wait_closed("cycle");
    check("cycle_idle", {dO, dC, door_busy, door_closed}, 4'b0001);

    // ---- obstruct held for 20 dwell cycles ----
    pulse_arrive();
    wait_dO_low("obs");
    obstruct = 1'b1;
    begin
      int dc_seen = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (dC) dc_seen++; end
      check("obs_no_dC", 4'(dc_seen), 4'd0);
    end
    obstruct = 1'b0;
    count_to_dC("obs");

    // ---- obstruct during closing at bar 1100 ----
    wait_door("reopen", 4'b1100);
    obstruct = 1'b1;
    tick();
    obstruct = 1'b0;
    check("reopen_cmd", {2'b00, dO, dC}, 4'b0010);
    wait_dO_low("reopen");
    count_to_dC("reopen");
    wait_closed("reopen");

    // ---- close_btn on the 2nd dwell cycle ----
    pulse_arrive();
    wait_dO_low("cbtn");
    tick();
    close_btn = 1'b1;
    tick();
    close_btn = 1'b0;
    check("cbtn_dC", {2'b00, dO, dC}, 4'b0001);
    wait_closed("cbtn");

    // ---- open_btn and close_btn together in dwell ----
    pulse_arrive();
    wait_dO_low("both");
    open_btn = 1'b1;
    close_btn = 1'b1;
    begin
      int dc_seen = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (dC) dc_seen++; end
      check("both_no_dC", 4'(dc_seen), 4'd0);
    end
    open_btn = 1'b0;
    close_btn = 1'b0;
    count_to_dC("both");
    wait_closed("both");

    // ---- reset while opening at bar 1000 ----
    pulse_arrive();
    wait_door("rst", 4'b1000);
    rst_n = 1'b0;
    tick();
    check("rst_mid_open", {dO, dC, door_busy, door_closed}, 4'b0010);
    rst_n = 1'b1;
    tick();
    check("rst_then_close", {2'b00, dO, dC}, 4'b0001);
    wait_closed("rst");

    // ---- randomized run against the reference model ----
    {rst_n, arrive, open_btn, close_btn, obstruct} = 5'b0_0000;
    model_step(rst_n, arrive, open_btn, close_btn, obstruct, door);
    for (int i = 0; i < 3000; i++) begin
      tick();
      check($sformatf("rand%0d", i), {dO, dC, door_busy, door_closed}, m_exp);
      rst_n     = ($urandom_range(0, 199) != 0);
      arrive    = ($urandom_range(0, 15) == 0);
      open_btn  = ($urandom_range(0, 19) == 0);
      close_btn = ($urandom_range(0, 9) == 0);
      obstruct  = ($urandom_range(0, 15) == 0);
      model_step(rst_n, arrive, open_btn, close_btn, obstruct, door);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
